// File: rtl/frame_sched_pkg.sv
// Shared definitions for the frame row scheduler: FSM state encoding,
// decimation encoding and default frame geometry.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_CURR = 2'b00,
    ST_LAST = 2'b01,
    ST_WAIT = 2'b10
  } sched_state_e;

  localparam logic [1:0] DECIM_1_1  = 2'd0;
  localparam logic [1:0] DECIM_2_1  = 2'd1;
  localparam logic [1:0] DECIM_4_1  = 2'd2;
  localparam logic [1:0] DECIM_RSVD = 2'd3;

  localparam int DEF_FRAME_W   = 640;
  localparam int DEF_FRAME_H   = 480;
  localparam int DEF_PIX_W     = 16;
  localparam int DEF_BUF_DEPTH = 64;

  // Log2 of the sampling step; the reserved code falls back to 1:1.
  function automatic logic [1:0] decim_shift(input logic [1:0] decim);
    case (decim)
      DECIM_2_1: return 2'd1;
      DECIM_4_1: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sched_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is visible on o_dout
// whenever o_empty is low. A push while full is accepted only alongside a pop.
module sched_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  assign o_dout  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/frame_row_scheduler.sv
// Crops/decimates a raster pixel stream into a FIFO and sequences row writes,
// previous-row reads and compressor handoff. SCHED_DROP_CNT_EN adds o_drop_cnt.
module frame_row_scheduler
  import frame_sched_pkg::*;
#(
  parameter int FRAME_W   = DEF_FRAME_W,
  parameter int FRAME_H   = DEF_FRAME_H,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_pix_valid,
  input  logic [PIX_W-1:0]             i_pix,
  input  logic                         i_vsync,
  input  logic [$clog2(FRAME_W):0]     i_win_x0,
  input  logic [$clog2(FRAME_W):0]     i_win_w,
  input  logic [$clog2(FRAME_H):0]     i_win_y0,
  input  logic [$clog2(FRAME_H):0]     i_win_h,
  input  logic [1:0]                   i_decim,
  output logic                         o_wr_req,
  output logic [PIX_W-1:0]             o_wr_pix,
  input  logic                         i_wr_busy,
  output logic                         o_rd_req,
  input  logic                         i_rd_busy,
  input  logic                         i_cur_row_full,
  input  logic                         i_last_row_full,
  input  logic                         i_cmp_ready,
  input  logic                         i_out_full,
  output logic [1:0]                   o_state,
  output logic [$clog2(FRAME_H):0]     o_row_cnt,
`ifdef SCHED_DROP_CNT_EN
  output logic [15:0]                  o_drop_cnt,
`endif
  output logic                         o_overflow
);

  localparam int XW = $clog2(FRAME_W) + 1;
  localparam int YW = $clog2(FRAME_H) + 1;
  localparam int XE = XW + 1;
  localparam int YE = YW + 1;
  localparam logic [XW-1:0] C_X_MAX = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] C_Y_MAX = YW'(FRAME_H - 1);
  localparam logic [XE-1:0] C_FW    = XE'(FRAME_W);
  localparam logic [YE-1:0] C_FH    = YE'(FRAME_H);

  logic [XW-1:0]    r_x, r_x0, r_w;
  logic [YW-1:0]    r_y, r_y0, r_h;
  logic [1:0]       r_decim;
  sched_state_e     r_state;
  logic             r_wr_req, r_rd_req, r_overflow;
  logic [PIX_W-1:0] r_wr_pix;
  logic [YW-1:0]    r_row_cnt;

  logic [XW-1:0]    w_w_clamp;
  logic [YW-1:0]    w_h_clamp;
  logic [XE-1:0]    w_x_end;
  logic [YE-1:0]    w_y_end;
  logic [1:0]       w_shift;
  logic [XW-1:0]    w_x_step, w_dx;
  logic [YW-1:0]    w_y_step, w_dy;
  logic             w_x_in, w_y_in, w_accept, w_row_last;
  logic             w_pop, w_drop, w_full, w_empty;
  logic [PIX_W-1:0] w_head;

  // Window clamp applied to the incoming config before it is latched.
  always_comb begin
    w_w_clamp = i_win_w;
    if ({1'b0, i_win_x0} >= C_FW) w_w_clamp = '0;
    else if (({1'b0, i_win_x0} + {1'b0, i_win_w}) > C_FW) w_w_clamp = XW'(C_FW - {1'b0, i_win_x0});
    else w_w_clamp = i_win_w;
    w_h_clamp = i_win_h;
    if ({1'b0, i_win_y0} >= C_FH) w_h_clamp = '0;
    else if (({1'b0, i_win_y0} + {1'b0, i_win_h}) > C_FH) w_h_clamp = YW'(C_FH - {1'b0, i_win_y0});
    else w_h_clamp = i_win_h;
  end

  assign w_shift    = decim_shift(r_decim);
  assign w_x_step   = XW'(1) << w_shift;
  assign w_y_step   = YW'(1) << w_shift;
  assign w_x_end    = {1'b0, r_x0} + {1'b0, r_w};
  assign w_y_end    = {1'b0, r_y0} + {1'b0, r_h};
  assign w_dx       = r_x - r_x0;
  assign w_dy       = r_y - r_y0;
  assign w_x_in     = (r_x >= r_x0) && ({1'b0, r_x} < w_x_end)
                      && ((w_dx & (w_x_step - XW'(1))) == '0);
  assign w_y_in     = (r_y >= r_y0) && ({1'b0, r_y} < w_y_end)
                      && ((w_dy & (w_y_step - YW'(1))) == '0);
  // The pixel arriving with i_vsync belongs to no frame and is ignored.
  assign w_accept   = i_pix_valid && !i_vsync && w_x_in && w_y_in;
  assign w_row_last = ({1'b0, r_x} + {1'b0, w_x_step}) >= w_x_end;
  assign w_pop      = (r_state == ST_CURR) && !i_cur_row_full && !i_wr_busy
                      && !w_empty && !i_vsync;
  assign w_drop     = w_accept && w_full && !w_pop;

  sched_sync_fifo #(.W(PIX_W), .DEPTH(BUF_DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_flush (i_vsync),
    .i_push  (w_accept),
    .i_din   (i_pix),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST || i_vsync) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_pix_valid) begin
      if (r_x == C_X_MAX) begin
        r_x <= '0;
        r_y <= (r_y == C_Y_MAX) ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= XW'(FRAME_W);
      r_h     <= YW'(FRAME_H);
      r_decim <= DECIM_1_1;
    end else if (i_vsync) begin
      r_x0    <= i_win_x0;
      r_y0    <= i_win_y0;
      r_w     <= w_w_clamp;
      r_h     <= w_h_clamp;
      r_decim <= i_decim;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_CURR;
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
      r_wr_pix <= '0;
    end else if (i_vsync) begin
      r_state  <= ST_CURR;
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
    end else begin
      case (r_state)
        ST_CURR: begin
          r_rd_req <= 1'b0;
          if (i_cur_row_full) begin
            r_state  <= ST_LAST;
            r_wr_req <= 1'b0;
          end else if (w_pop) begin
            r_wr_req <= 1'b1;
            r_wr_pix <= w_head;
          end else begin
            r_wr_req <= 1'b0;
          end
        end
        ST_LAST: begin
          r_wr_req <= 1'b0;
          if (i_last_row_full) begin
            r_state  <= ST_WAIT;
            r_rd_req <= 1'b0;
          end else if (!i_rd_busy && !r_rd_req) begin
            r_rd_req <= 1'b1;
          end else begin
            r_rd_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          r_wr_req <= 1'b0;
          r_rd_req <= 1'b0;
          if (i_cmp_ready && !i_out_full) r_state <= ST_CURR;
        end
        default: begin
          r_state  <= ST_CURR;
          r_wr_req <= 1'b0;
          r_rd_req <= 1'b0;
        end
      endcase
    end
  end

  // A row completes on its last sampled pixel, whether it fit or was dropped.
  always_ff @(posedge CLK) begin
    if (RST || i_vsync) begin
      r_row_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept && w_row_last) r_row_cnt <= r_row_cnt + YW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef SCHED_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge CLK) begin
    if (RST || i_vsync) r_drop_cnt <= 16'd0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

  assign o_state    = r_state;
  assign o_wr_req   = r_wr_req;
  assign o_wr_pix   = r_wr_pix;
  assign o_rd_req   = r_rd_req;
  assign o_row_cnt  = r_row_cnt;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_frame_row_scheduler.sv
// Directed bench for frame_row_scheduler on a reduced 64x32 frame with a
// 64-deep buffer; pixel value is y*64+x so written data can be summed by hand.
module tb_frame_row_scheduler;

  localparam int FW = 64;
  localparam int FH = 32;

  logic        CLK;
  logic        RST;
  logic        i_pix_valid;
  logic [15:0] i_pix;
  logic        i_vsync;
  logic [6:0]  i_win_x0, i_win_w;
  logic [5:0]  i_win_y0, i_win_h;
  logic [1:0]  i_decim;
  logic        o_wr_req;
  logic [15:0] o_wr_pix;
  logic        i_wr_busy;
  logic        o_rd_req;
  logic        i_rd_busy;
  logic        i_cur_row_full, i_last_row_full, i_cmp_ready, i_out_full;
  logic [1:0]  o_state;
  logic [5:0]  o_row_cnt;
  logic        o_overflow;
`ifdef SCHED_DROP_CNT_EN
  logic [15:0] o_drop_cnt;
`endif

  frame_row_scheduler #(.FRAME_W(FW), .FRAME_H(FH), .PIX_W(16), .BUF_DEPTH(64)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .i_pix_valid     (i_pix_valid),
    .i_pix           (i_pix),
    .i_vsync         (i_vsync),
    .i_win_x0        (i_win_x0),
    .i_win_w         (i_win_w),
    .i_win_y0        (i_win_y0),
    .i_win_h         (i_win_h),
    .i_decim         (i_decim),
    .o_wr_req        (o_wr_req),
    .o_wr_pix        (o_wr_pix),
    .i_wr_busy       (i_wr_busy),
    .o_rd_req        (o_rd_req),
    .i_rd_busy       (i_rd_busy),
    .i_cur_row_full  (i_cur_row_full),
    .i_last_row_full (i_last_row_full),
    .i_cmp_ready     (i_cmp_ready),
    .i_out_full      (i_out_full),
    .o_state         (o_state),
    .o_row_cnt       (o_row_cnt),
`ifdef SCHED_DROP_CNT_EN
    .o_drop_cnt      (o_drop_cnt),
`endif
    .o_overflow      (o_overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  int          wr_cnt = 0;
  longint      wr_sum = 0;
  int          first_idx = 0;
  logic [15:0] first_pix = 16'd0;
  logic [15:0] last_pix = 16'd0;
  int          tb_x = 0;
  int          tb_y = 0;
  int          wr_base;
  longint      sum_base;
  int          rd_pulses;

  // Write-port monitor sampled on the falling edge.
  always @(negedge CLK) begin
    if (o_wr_req === 1'b1) begin
      if (wr_cnt == first_idx) first_pix = o_wr_pix;
      last_pix = o_wr_pix;
      wr_sum   = wr_sum + longint'(o_wr_pix);
      wr_cnt   = wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_win(input int x0, input int w, input int y0, input int h, input int d);
    i_win_x0 = 7'(x0);
    i_win_w  = 7'(w);
    i_win_y0 = 6'(y0);
    i_win_h  = 6'(h);
    i_decim  = 2'(d);
  endtask

  task automatic vsync_pulse();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    tb_x = 0;
    tb_y = 0;
  endtask

  task automatic stream(input int npix);
    for (int i = 0; i < npix; i++) begin
      i_pix_valid = 1'b1;
      i_pix       = 16'(tb_y * FW + tb_x);
      tick();
      if (tb_x == FW - 1) begin
        tb_x = 0;
        tb_y = (tb_y == FH - 1) ? 0 : tb_y + 1;
      end else begin
        tb_x = tb_x + 1;
      end
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic mark();
    wr_base   = wr_cnt;
    sum_base  = wr_sum;
    first_idx = wr_cnt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RST = 1'b1; i_vsync = 1'b1; i_pix_valid = 1'b0; i_pix = 16'd0;
    i_wr_busy = 1'b0; i_rd_busy = 1'b0; i_cur_row_full = 1'b0;
    i_last_row_full = 1'b0; i_cmp_ready = 1'b0; i_out_full = 1'b0;
    set_win(5, 0, 3, 0, 1);
    idle(3);
    RST = 1'b0; i_vsync = 1'b0;
    tick();
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_wr_req", 64'(o_wr_req), 64'd0);
    chk("rst_rd_req", 64'(o_rd_req), 64'd0);
    chk("rst_wr_pix", 64'(o_wr_pix), 64'd0);
    chk("rst_row_cnt", 64'(o_row_cnt), 64'd0);
    chk("rst_overflow", 64'(o_overflow), 64'd0);

    // Reset-default full window, no vsync after reset.
    mark();
    stream(FW * FH);
    idle(10);
    chk("full_wr_count", 64'(wr_cnt - wr_base), 64'd2048);
    chk("full_row_cnt", 64'(o_row_cnt), 64'd32);
    chk("full_overflow", 64'(o_overflow), 64'd0);
    chk("full_sum", 64'(wr_sum - sum_base), 64'd2096128);

    // Window with 2:1 decimation.
    set_win(8, 32, 4, 16, 1);
    mark();
    vsync_pulse();
    stream(FW * FH);
    idle(10);
    chk("win_wr_count", 64'(wr_cnt - wr_base), 64'd128);
    chk("win_row_cnt", 64'(o_row_cnt), 64'd8);
    chk("win_first_pix", 64'(first_pix), 64'd264);
    chk("win_last_pix", 64'(last_pix), 64'd1190);
    chk("win_sum", 64'(wr_sum - sum_base), 64'd93056);
    chk("win_overflow", 64'(o_overflow), 64'd0);

    // Clamped window at the frame corner with 4:1 decimation.
    set_win(48, 32, 28, 10, 2);
    mark();
    vsync_pulse();
    stream(FW * FH);
    idle(10);
    chk("clamp_wr_count", 64'(wr_cnt - wr_base), 64'd4);
    chk("clamp_row_cnt", 64'(o_row_cnt), 64'd1);
    chk("clamp_sum", 64'(wr_sum - sum_base), 64'd7384);

    // Reserved decimation code behaves as 1:1.
    set_win(60, 4, 30, 2, 3);
    mark();
    vsync_pulse();
    stream(FW * FH);
    idle(10);
    chk("rsvd_wr_count", 64'(wr_cnt - wr_base), 64'd8);
    chk("rsvd_row_cnt", 64'(o_row_cnt), 64'd2);
    chk("rsvd_sum", 64'(wr_sum - sum_base), 64'd16108);

    // Zero width accepts nothing.
    set_win(0, 0, 0, 32, 0);
    mark();
    vsync_pulse();
    stream(FW * FH);
    idle(10);
    chk("w0_wr_count", 64'(wr_cnt - wr_base), 64'd0);
    chk("w0_row_cnt", 64'(o_row_cnt), 64'd0);

    // Fill the buffer, then push and pop together while full.
    set_win(0, 64, 0, 32, 0);
    i_wr_busy = 1'b1;
    mark();
    vsync_pulse();
    stream(64);
    i_wr_busy = 1'b0;
    stream(10);
    idle(80);
    chk("fullpp_wr_count", 64'(wr_cnt - wr_base), 64'd74);
    chk("fullpp_overflow", 64'(o_overflow), 64'd0);
    chk("fullpp_row_cnt", 64'(o_row_cnt), 64'd1);

    // Overflow: 100 pixels into a 64-deep buffer while writes are stalled.
    i_wr_busy = 1'b1;
    mark();
    vsync_pulse();
    stream(100);
    tick();
    chk("ovf_flag", 64'(o_overflow), 64'd1);
    chk("ovf_row_cnt", 64'(o_row_cnt), 64'd1);
    chk("ovf_no_write", 64'(wr_cnt - wr_base), 64'd0);
`ifdef SCHED_DROP_CNT_EN
    chk("ovf_drop_cnt", 64'(o_drop_cnt), 64'd36);
`endif
    i_wr_busy = 1'b0;
    idle(80);
    chk("ovf_drain_count", 64'(wr_cnt - wr_base), 64'd64);
    chk("ovf_sticky", 64'(o_overflow), 64'd1);
    vsync_pulse();
    chk("ovf_vsync_clear", 64'(o_overflow), 64'd0);
`ifdef SCHED_DROP_CNT_EN
    chk("drop_vsync_clear", 64'(o_drop_cnt), 64'd0);
`endif

    // Two-cycle latency from accepted pixel to write pulse.
    i_pix_valid = 1'b1;
    i_pix = 16'h1234;
    tick();
    i_pix_valid = 1'b0;
    chk("lat_n1_wr_req", 64'(o_wr_req), 64'd0);
    tick();
    chk("lat_n2_wr_req", 64'(o_wr_req), 64'd1);
    chk("lat_n2_wr_pix", 64'(o_wr_pix), 64'h1234);
    idle(4);

    // Row-full beats a pending write; then read pacing and WAIT hold.
    i_wr_busy = 1'b1;
    i_rd_busy = 1'b1;
    vsync_pulse();
    stream(3);
    tick();
    mark();
    i_wr_busy = 1'b0;
    i_cur_row_full = 1'b1;
    tick();
    i_cur_row_full = 1'b0;
    chk("rowfull_state", 64'(o_state), 64'd1);
    chk("rowfull_no_wr", 64'(o_wr_req), 64'd0);
    rd_pulses = 0;
    i_rd_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_rd_req === 1'b1) rd_pulses++;
    end
    i_rd_busy = 1'b1;
    tick();
    if (o_rd_req === 1'b1) rd_pulses++;
    chk("rd_pulse_count", 64'(rd_pulses), 64'd5);
    chk("last_no_wr", 64'(wr_cnt - wr_base), 64'd0);
    i_last_row_full = 1'b1;
    tick();
    i_last_row_full = 1'b0;
    chk("to_wait_state", 64'(o_state), 64'd2);
    i_cmp_ready = 1'b1;
    i_out_full = 1'b1;
    idle(3);
    chk("wait_hold_state", 64'(o_state), 64'd2);
    i_out_full = 1'b0;
    tick();
    i_cmp_ready = 1'b0;
    chk("wait_exit_state", 64'(o_state), 64'd0);
    idle(10);
    i_rd_busy = 1'b0;

    // vsync while 20 pixels sit in the buffer during LAST.
    set_win(0, 16, 0, 32, 0);
    i_wr_busy = 1'b1;
    vsync_pulse();
    stream(68);
    i_cur_row_full = 1'b1;
    tick();
    i_cur_row_full = 1'b0;
    chk("flush_pre_state", 64'(o_state), 64'd1);
    chk("flush_pre_row_cnt", 64'(o_row_cnt), 64'd1);
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    chk("flush_state", 64'(o_state), 64'd0);
    chk("flush_row_cnt", 64'(o_row_cnt), 64'd0);
    mark();
    i_wr_busy = 1'b0;
    idle(30);
    chk("flush_empty", 64'(wr_cnt - wr_base), 64'd0);
    chk("flush_overflow", 64'(o_overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
